// File: rtl/fifo_ctrl_if.sv
// Push/pop and memory-control bundle between fifo_ctrl (slave) and the
// surrounding logic that drives pushes/pops and owns the storage array (master).
interface fifo_ctrl_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 8
) ();
  logic                  iPush;
  logic [DATA_WIDTH-1:0] iPushData;
  logic                  iPop;
  logic [DATA_WIDTH-1:0] oPopData;
  logic                  oPopValid;
  logic                  oFull;
  logic                  oEmpty;
  logic                  oAlmostFull;
  logic                  oAlmostEmpty;
  logic [ADDR_WIDTH:0]   oCount;
  logic                  oError;
  logic                  oMemWriteEnable;
  logic [ADDR_WIDTH-1:0] oMemWriteAddress;
  logic [DATA_WIDTH-1:0] oMemWriteData;
  logic [ADDR_WIDTH-1:0] oMemReadAddress;
  logic [DATA_WIDTH-1:0] iMemReadData;

  modport slave (
    input  iPush, iPushData, iPop, iMemReadData,
    output oPopData, oPopValid, oFull, oEmpty, oAlmostFull, oAlmostEmpty,
           oCount, oError, oMemWriteEnable, oMemWriteAddress, oMemWriteData,
           oMemReadAddress
  );

  modport master (
    output iPush, iPushData, iPop, iMemReadData,
    input  oPopData, oPopValid, oFull, oEmpty, oAlmostFull, oAlmostEmpty,
           oCount, oError, oMemWriteEnable, oMemWriteAddress, oMemWriteData,
           oMemReadAddress
  );
endinterface

// File: rtl/fifo_ctrl.sv
// FIFO controller for an external registered-read dual-port memory: pointers, count, flags.
// Optional sticky overflow/underflow flag built only when FIFO_CTRL_ERR_EN is defined.
module fifo_ctrl #(
  parameter int DATA_WIDTH   = 6,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 8,
  parameter int ALMOST_FULL  = 6,
  parameter int ALMOST_EMPTY = 1
) (
  input  logic        Clock,
  input  logic        iReset_L,
  fifo_ctrl_if.slave  bus
);

  localparam int                    CNT_W    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_AF   = CNT_W'(ALMOST_FULL);
  localparam logic [CNT_W-1:0]      CNT_AE   = CNT_W'(ALMOST_EMPTY);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  pop_valid_q, pop_valid_d;
  logic                  push_acc, pop_acc;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  always_comb begin
    // NOTE: every variable gets a value on every path through this block,
    // otherwise synthesis infers a latch to hold the missing case.
    push_acc    = bus.iPush && (!full_q || bus.iPop);
    pop_acc     = bus.iPop && !empty_q;
    wr_ptr_d    = push_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop_acc  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d     = count_q;
    if (push_acc && !pop_acc)      count_d = count_q + CNT_W'(1);
    else if (!push_acc && pop_acc) count_d = count_q - CNT_W'(1);
    full_d      = (count_d == CNT_FULL);
    empty_d     = (count_d == '0);
    afull_d     = (count_d >= CNT_AF);
    aempty_d    = (count_d <= CNT_AE);
    pop_valid_d = pop_acc;
  end

  always_ff @(posedge Clock) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (!iReset_L) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      pop_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      pop_valid_q <= pop_valid_d;
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  logic err_q, err_d;

  // Sticky: a dropped push (full, no pop) or an ignored pop (empty) latches until reset.
  always_comb begin
    err_d = err_q | (bus.iPush && full_q && !bus.iPop) | (bus.iPop && empty_q);
  end

  always_ff @(posedge Clock) begin
    if (!iReset_L) err_q <= 1'b0;
    else           err_q <= err_d;
  end

  assign bus.oError = err_q;
`else
  assign bus.oError = 1'b0;
`endif

  // Write enable is held low combinationally while reset is asserted.
  assign bus.oMemWriteEnable  = push_acc && iReset_L;
  assign bus.oMemWriteAddress = wr_ptr_q;
  assign bus.oMemWriteData    = bus.iPushData;
  assign bus.oMemReadAddress  = rd_ptr_q;
  assign bus.oPopData         = bus.iMemReadData;
  assign bus.oPopValid        = pop_valid_q;
  assign bus.oFull            = full_q;
  assign bus.oEmpty           = empty_q;
  assign bus.oAlmostFull      = afull_q;
  assign bus.oAlmostEmpty     = aempty_q;
  assign bus.oCount           = count_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl paired with a behavioural registered-read memory; a queue
// model is compared every cycle, plus literal checks on directed scenarios.
module tb_fifo_ctrl;

  localparam int DW    = 6;
  localparam int AW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;
`ifdef FIFO_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic Clock = 1'b0;
  logic iReset_L;
  always #5 Clock = ~Clock;

  fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)
  ) dut (
    .Clock    (Clock),
    .iReset_L (iReset_L),
    .bus      (bus)
  );

  // Storage array with registered read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge Clock) begin
    if (bus.oMemWriteEnable) mem[bus.oMemWriteAddress] <= bus.oMemWriteData;
    bus.iMemReadData <= mem[bus.oMemReadAddress];
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, pointers as push/pop counts mod DEPTH.
  logic [DW-1:0] model_q [$];
  logic [DW-1:0] m_data;
  bit            m_valid, m_err, model_ready, push_ok, pop_ok;
  int            m_wr, m_rd, sz;

  always @(posedge Clock) begin
    if (!iReset_L) begin
      model_q.delete();
      m_valid = 1'b0; m_err = 1'b0; m_wr = 0; m_rd = 0;
      model_ready = 1'b1;
    end else if (model_ready) begin
      sz      = model_q.size();
      push_ok = bus.iPush && (sz < DEPTH || bus.iPop);
      pop_ok  = bus.iPop && sz > 0;
      if (ERR_EN && ((bus.iPush && sz == DEPTH && !bus.iPop) || (bus.iPop && sz == 0)))
        m_err = 1'b1;
      m_valid = pop_ok;
      if (pop_ok) begin
        m_data = model_q.pop_front();
        m_rd   = (m_rd + 1) % DEPTH;
      end
      if (push_ok) begin
        model_q.push_back(bus.iPushData);
        m_wr = (m_wr + 1) % DEPTH;
      end
    end
  end

  logic [DW-1:0] popped [$];
  bit            exp_we;

  initial begin
    forever begin
      @(negedge Clock);
      #1;
      if (model_ready) begin
        check("count",   bus.oCount,       model_q.size());
        check("full",    bus.oFull,        model_q.size() == DEPTH);
        check("empty",   bus.oEmpty,       model_q.size() == 0);
        check("afull",   bus.oAlmostFull,  model_q.size() >= AF);
        check("aempty",  bus.oAlmostEmpty, model_q.size() <= AE);
        check("pvalid",  bus.oPopValid,    m_valid);
        check("error",   bus.oError,       m_err);
        check("raddr",   bus.oMemReadAddress, m_rd);
        if (m_valid) check("pdata", bus.oPopData, m_data);
        exp_we = iReset_L && bus.iPush && (model_q.size() < DEPTH || bus.iPop);
        check("we", bus.oMemWriteEnable, exp_we);
        if (exp_we) begin
          check("waddr", bus.oMemWriteAddress, m_wr);
          check("wdata", bus.oMemWriteData,    bus.iPushData);
        end
        if (bus.oPopValid) popped.push_back(bus.oPopData);
      end
    end
  end

  task automatic cycle(input logic p, input logic [DW-1:0] d, input logic o);
    @(negedge Clock);
    bus.iPush = p; bus.iPushData = d; bus.iPop = o;
  endtask

  task automatic check_popped(input string name, input logic [DW-1:0] exp [$]);
    check({name, "_n"}, popped.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < popped.size()) check(name, popped[i], exp[i]);
  endtask

  logic [DW-1:0] exp_list [$];

  initial begin
    iReset_L = 1'b0;
    bus.iPush = 1'b1; bus.iPushData = '0; bus.iPop = 1'b0;
    repeat (2) @(negedge Clock);
    #2 check("we_in_reset", bus.oMemWriteEnable, 0);
    cycle(0, 0, 0); iReset_L = 1'b1;
    repeat (3) cycle(0, 0, 0);
    #2;
    check("rst_empty",  bus.oEmpty, 1);
    check("rst_count",  bus.oCount, 0);
    check("rst_pvalid", bus.oPopValid, 0);
    check("rst_we",     bus.oMemWriteEnable, 0);
    check("rst_aempty", bus.oAlmostEmpty, 1);

    // Fill 0x01..0x08, then drain in order.
    for (int i = 1; i <= 8; i++) begin
      cycle(1, DW'(i), 0);
      #2;
      if (i == 6) check("afull_at5", bus.oAlmostFull, 0);
      if (i == 7) check("afull_at6", bus.oAlmostFull, 1);
      if (i == 8) check("full_at7",  bus.oFull, 0);
    end
    cycle(0, 0, 0);
    #2 check("full_at8", bus.oFull, 1);
    check("count8", bus.oCount, 8);
    popped.delete();
    repeat (8) cycle(0, 0, 1);
    repeat (2) cycle(0, 0, 0);
    exp_list = {6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08};
    check_popped("order", exp_list);
    #2 check("drained_empty", bus.oEmpty, 1);

    // Full FIFO push+pop: both accepted, new word lands at wrapped address 0.
    for (int i = 0; i < 8; i++) cycle(1, DW'(8'h10 + i), 0);
    cycle(0, 0, 0);
    popped.delete();
    cycle(1, 6'h2A, 1);
    #2 check("pp_full_we", bus.oMemWriteEnable, 1);
    check("pp_full_waddr", bus.oMemWriteAddress, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1);
      if (i == 0) #2 check("pp_full_count", bus.oCount, 8);
    end
    repeat (2) cycle(0, 0, 0);
    exp_list = {6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16, 6'h17, 6'h2A};
    check_popped("pp_full", exp_list);

    // Empty FIFO push+pop: pop rejected, no fall-through.
    popped.delete();
    cycle(1, 6'h15, 1);
    cycle(0, 0, 0);
    #2 check("pp_empty_pvalid", bus.oPopValid, 0);
    check("pp_empty_count", bus.oCount, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    #2 check("pp_empty_pvalid2", bus.oPopValid, 1);
    check("pp_empty_data", bus.oPopData, 6'h15);

    // Overflow: push while full is dropped.
    for (int i = 0; i < 8; i++) cycle(1, DW'(8'h20 + i), 0);
    cycle(1, 6'h33, 0);
    #2 check("ovf_we", bus.oMemWriteEnable, 0);
    cycle(0, 0, 0);
    #2 check("ovf_count", bus.oCount, 8);
    check("ovf_error", bus.oError, ERR_EN);
    popped.delete();
    repeat (8) cycle(0, 0, 1);
    repeat (2) cycle(0, 0, 0);
    exp_list = {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27};
    check_popped("ovf_contents", exp_list);

    // Reset with 5 stored entries and a pop on the reset edge.
    for (int i = 1; i <= 5; i++) cycle(1, DW'(i), 0);
    cycle(0, 0, 1); iReset_L = 1'b0;
    cycle(0, 0, 0); iReset_L = 1'b1;
    #2 check("mid_rst_count", bus.oCount, 0);
    check("mid_rst_empty",  bus.oEmpty, 1);
    check("mid_rst_pvalid", bus.oPopValid, 0);
    check("mid_rst_error",  bus.oError, 0);

    // Underflow after reset.
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    #2 check("udf_pvalid", bus.oPopValid, 0);
    check("udf_error", bus.oError, ERR_EN);

    popped.delete();
    cycle(1, 6'h3F, 0);
    cycle(0, 0, 1);
    repeat (2) cycle(0, 0, 0);
    exp_list = {6'h3F};
    check_popped("post_rst", exp_list);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
